// File: rtl/vdrive_pkg.sv
// ---------------------------------------------------------------------------
// vdrive_pkg
//   Shared definitions for the vdrive sprite engine: draw FSM states, screen
//   geometry and helpers that derive sprite shape from the DXYN row count.
//   A row count of 0 selects the 16x16 sprite (two bytes per row).
// ---------------------------------------------------------------------------
package vdrive_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        RD,
        WR,
        DONE
    } state_t;

    localparam int unsigned HRES = 128;
    localparam int unsigned VRES = 64;

    function automatic logic wide_sprite(input logic [3:0] rows);
        return (rows == 4'd0);
    endfunction

    function automatic logic [1:0] bytes_per_row(input logic [3:0] rows);
        return (rows == 4'd0) ? 2'd2 : 2'd1;
    endfunction

    // Index of the final column in a row (width - 1).
    function automatic logic [3:0] last_col(input logic [3:0] rows);
        return (rows == 4'd0) ? 4'd15 : 4'd7;
    endfunction

    // Index of the final row (height - 1).
    function automatic logic [3:0] last_row(input logic [3:0] rows);
        return (rows == 4'd0) ? 4'd15 : (rows - 4'd1);
    endfunction

endpackage

// File: rtl/vdrive_sprite_rowbuf.sv
// ---------------------------------------------------------------------------
// vdrive_sprite_rowbuf
//   Holds one sprite row (up to 16 pixels). Bytes are loaded individually:
//   byte 0 lands in the upper half, byte 1 in the lower half, so column c
//   always maps to bit 15-c whether the row is 8 or 16 pixels wide.
// Ports
//   clk, reset_n   clock, asynchronous active-low reset
//   load           capture byte_in this cycle
//   byte_sel       0 = first (MSB) byte, 1 = second byte
//   byte_in        sprite byte from program memory
//   col            column index, 0 = leftmost pixel
//   pixel_bit      sprite bit for the selected column
// ---------------------------------------------------------------------------
module vdrive_sprite_rowbuf (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load,
    input  logic       byte_sel,
    input  logic [7:0] byte_in,
    input  logic [3:0] col,
    output logic       pixel_bit
);

    logic [15:0] row_q;
    logic [15:0] row_d;

    always_comb begin
        row_d = row_q;
        if (load) begin
            if (byte_sel) begin
                row_d[7:0] = byte_in;
            end else begin
                row_d[15:8] = byte_in;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_q <= '0;
        end else begin
            row_q <= row_d;
        end
    end

    assign pixel_bit = row_q[4'd15 - col];

endmodule

// File: rtl/vdrive_sprite.sv
// ---------------------------------------------------------------------------
// vdrive_sprite
//   CHIP-8 DXYN-style sprite draw engine. Fetches sprite bytes from program
//   memory and XOR-toggles 2-bit VRAM pixels by read-modify-write, reporting
//   whether any set plane bit was cleared (collision).
// Configuration
//   VDRIVE_SPRITE_WRAP_EN  defined: pixels past the right/bottom edge wrap
//                          around; undefined: they are clipped.
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   start                        draw request (sampled only in IDLE)
//   sprite_x/y, sprite_rows      origin and row count (0 = 16x16)
//   sprite_addr, plane_mask      first sprite byte, pixel bits to toggle
//   mem_rd/mem_addr/mem_data     program memory port (1-cycle read latency)
//   vram_hpos/vpos               VRAM address, held across RD and WR
//   vram_rd_pixel                VRAM data for the previous cycle's address
//   vram_wr/vram_wr_pixel        VRAM write port
//   busy, done, collision        CPU-side status
// ---------------------------------------------------------------------------
module vdrive_sprite
    import vdrive_pkg::*;
#(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned HPOS_W = $clog2(HRES),
    parameter int unsigned VPOS_W = $clog2(VRES)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [HPOS_W-1:0] sprite_x,
    input  logic [VPOS_W-1:0] sprite_y,
    input  logic [3:0]        sprite_rows,
    input  logic [ADDR_W-1:0] sprite_addr,
    input  logic [1:0]        plane_mask,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_data,
    output logic [HPOS_W-1:0] vram_hpos,
    output logic [VPOS_W-1:0] vram_vpos,
    input  logic [1:0]        vram_rd_pixel,
    output logic              vram_wr,
    output logic [1:0]        vram_wr_pixel,
    output logic              busy,
    output logic              done,
    output logic              collision
);

    state_t            state_q, state_d;
    logic [HPOS_W-1:0] x_q, x_d;
    logic [VPOS_W-1:0] y_q, y_d;
    logic [3:0]        rows_q, rows_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        mask_q, mask_d;
    logic [3:0]        row_q, row_d;
    logic [3:0]        col_q, col_d;
    logic              byte_q, byte_d;
    logic              collision_q, collision_d;

    logic              rb_load;
    logic              rb_bit;
    logic [HPOS_W:0]   hsum;
    logic [VPOS_W:0]   vsum;
    logic [4:0]        byte_off;
    logic              on_screen;
    logic              wr_en;

`ifdef VDRIVE_SPRITE_WRAP_EN
    localparam logic CLIP_EN = 1'b0;
`else
    localparam logic CLIP_EN = 1'b1;
`endif

    vdrive_sprite_rowbuf u_rowbuf (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (rb_load),
        .byte_sel  (byte_q),
        .byte_in   (mem_data),
        .col       (col_q),
        .pixel_bit (rb_bit)
    );

    // One extra bit so a carry past the screen edge is visible for clipping;
    // dropping it gives the wrapped coordinate.
    assign hsum = {1'b0, x_q} + (HPOS_W+1)'(col_q);
    assign vsum = {1'b0, y_q} + (VPOS_W+1)'(row_q);

    assign on_screen = ~(CLIP_EN & (hsum[HPOS_W] | vsum[VPOS_W]));
    assign wr_en     = rb_bit & (mask_q != 2'b00) & on_screen;

    // Byte offset within the sprite: row * bytes_per_row + byte index.
    assign byte_off = 5'(row_q) * 5'(bytes_per_row(rows_q)) + 5'(byte_q);

    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        rows_d        = rows_q;
        addr_d        = addr_q;
        mask_d        = mask_q;
        row_d         = row_q;
        col_d         = col_q;
        byte_d        = byte_q;
        collision_d   = collision_q;
        rb_load       = 1'b0;
        mem_rd        = 1'b0;
        mem_addr      = '0;
        vram_hpos     = '0;
        vram_vpos     = '0;
        vram_wr       = 1'b0;
        vram_wr_pixel = '0;
        busy          = 1'b0;
        done          = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    x_d         = sprite_x;
                    y_d         = sprite_y;
                    rows_d      = sprite_rows;
                    addr_d      = sprite_addr;
                    mask_d      = plane_mask;
                    row_d       = '0;
                    col_d       = '0;
                    byte_d      = 1'b0;
                    collision_d = 1'b0;
                    state_d     = FETCH;
                end
            end
            FETCH: begin
                busy     = 1'b1;
                mem_rd   = 1'b1;
                mem_addr = addr_q + ADDR_W'(byte_off);
                state_d  = LATCH;
            end
            LATCH: begin
                busy    = 1'b1;
                rb_load = 1'b1;
                if (wide_sprite(rows_q) && !byte_q) begin
                    byte_d  = 1'b1;
                    state_d = FETCH;
                end else begin
                    col_d   = '0;
                    state_d = RD;
                end
            end
            RD: begin
                busy      = 1'b1;
                vram_hpos = hsum[HPOS_W-1:0];
                vram_vpos = vsum[VPOS_W-1:0];
                state_d   = WR;
            end
            WR: begin
                busy          = 1'b1;
                vram_hpos     = hsum[HPOS_W-1:0];
                vram_vpos     = vsum[VPOS_W-1:0];
                vram_wr       = wr_en;
                vram_wr_pixel = vram_rd_pixel ^ mask_q;
                if (wr_en && ((vram_rd_pixel & mask_q) != 2'b00)) begin
                    collision_d = 1'b1;
                end
                if (col_q == last_col(rows_q)) begin
                    col_d  = '0;
                    byte_d = 1'b0;
                    if (row_q == last_row(rows_q)) begin
                        state_d = DONE;
                    end else begin
                        row_d   = row_q + 4'd1;
                        state_d = FETCH;
                    end
                end else begin
                    col_d   = col_q + 4'd1;
                    state_d = RD;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            rows_q      <= '0;
            addr_q      <= '0;
            mask_q      <= '0;
            row_q       <= '0;
            col_q       <= '0;
            byte_q      <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            rows_q      <= rows_d;
            addr_q      <= addr_d;
            mask_q      <= mask_d;
            row_q       <= row_d;
            col_q       <= col_d;
            byte_q      <= byte_d;
            collision_q <= collision_d;
        end
    end

    assign collision = collision_q;

endmodule

// File: tb/tb_vdrive_sprite.sv
module tb_vdrive_sprite;

    localparam int ADDR_W = 12;
    localparam int HPOS_W = 7;
    localparam int VPOS_W = 6;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic [HPOS_W-1:0] sprite_x;
    logic [VPOS_W-1:0] sprite_y;
    logic [3:0]        sprite_rows;
    logic [ADDR_W-1:0] sprite_addr;
    logic [1:0]        plane_mask;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;
    logic [HPOS_W-1:0] vram_hpos;
    logic [VPOS_W-1:0] vram_vpos;
    logic [1:0]        vram_rd_pixel;
    logic              vram_wr;
    logic [1:0]        vram_wr_pixel;
    logic              busy;
    logic              done;
    logic              collision;

    vdrive_sprite #(
        .ADDR_W (ADDR_W),
        .HPOS_W (HPOS_W),
        .VPOS_W (VPOS_W)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .sprite_x      (sprite_x),
        .sprite_y      (sprite_y),
        .sprite_rows   (sprite_rows),
        .sprite_addr   (sprite_addr),
        .plane_mask    (plane_mask),
        .mem_rd        (mem_rd),
        .mem_addr      (mem_addr),
        .mem_data      (mem_data),
        .vram_hpos     (vram_hpos),
        .vram_vpos     (vram_vpos),
        .vram_rd_pixel (vram_rd_pixel),
        .vram_wr       (vram_wr),
        .vram_wr_pixel (vram_wr_pixel),
        .busy          (busy),
        .done          (done),
        .collision     (collision)
    );

    always #5 clk = ~clk;

    // Environment: program memory and VRAM
    logic [7:0] pmem     [0:4095];
    logic [1:0] vram     [0:63][0:127];
    logic [1:0] ref_vram [0:63][0:127];
    logic [1:0] pre_vram [0:63][0:127];

    always @(posedge clk) begin
        if (mem_rd) mem_data <= pmem[mem_addr];
        vram_rd_pixel <= vram[vram_vpos][vram_hpos];
        if (vram_wr) vram[vram_vpos][vram_hpos] <= vram_wr_pixel;
    end

    typedef struct {
        int         x;
        int         y;
        logic [1:0] v;
    } wr_t;

    wr_t  act_wq[$];
    wr_t  exp_wq[$];
    int   act_rq[$];
    int   exp_rq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic exp_coll;

    always @(negedge clk) begin
        if (vram_wr) act_wq.push_back('{int'(vram_hpos), int'(vram_vpos), vram_wr_pixel});
        if (mem_rd)  act_rq.push_back(int'(mem_addr));
    end

    function automatic logic [31:0] outs();
        return {mem_rd, mem_addr, vram_hpos, vram_vpos, vram_wr, vram_wr_pixel, busy, done, collision};
    endfunction

    // Reference: plain DXYN semantics over the bench's expected VRAM image.
    task automatic model_draw(input int x, input int y, input int n, input int addr, input logic [1:0] mask);
        int bpr = (n == 0) ? 2 : 1;
        int h   = (n == 0) ? 16 : n;
        int w   = 8 * bpr;
        exp_wq.delete();
        exp_rq.delete();
        exp_coll = 1'b0;
        for (int r = 0; r < h; r++) begin
            int bits = 0;
            for (int b = 0; b < bpr; b++) begin
                int a = (addr + r * bpr + b) % 4096;
                exp_rq.push_back(a);
                bits = (bits << 8) | int'(pmem[a]);
            end
            for (int c = 0; c < w; c++) begin
                int px = x + c;
                int py = y + r;
                if (((bits >> (w - 1 - c)) & 1) == 0) continue;
`ifdef VDRIVE_SPRITE_WRAP_EN
                px = px % 128;
                py = py % 64;
`else
                if (px >= 128 || py >= 64) continue;
`endif
                if (mask != 2'b00) begin
                    logic [1:0] old = ref_vram[py][px];
                    if ((old & mask) != 2'b00) exp_coll = 1'b1;
                    ref_vram[py][px] = old ^ mask;
                    exp_wq.push_back('{px, py, old ^ mask});
                end
            end
        end
    endtask

    function automatic int wq_first_diff(input int base, input bit prefix_only);
        int na = act_wq.size() - base;
        if (!prefix_only && na != exp_wq.size()) return (na < exp_wq.size()) ? na : exp_wq.size();
        if (na > exp_wq.size()) return exp_wq.size();
        for (int i = 0; i < na; i++) begin
            if (act_wq[base+i].x != exp_wq[i].x || act_wq[base+i].y != exp_wq[i].y ||
                act_wq[base+i].v != exp_wq[i].v) return i;
        end
        return -1;
    endfunction

    function automatic int rq_first_diff(input int base);
        int na = act_rq.size() - base;
        if (na != exp_rq.size()) return (na < exp_rq.size()) ? na : exp_rq.size();
        for (int i = 0; i < na; i++) if (act_rq[base+i] != exp_rq[i]) return i;
        return -1;
    endfunction

    function automatic int vram_diffs();
        int d = 0;
        for (int y = 0; y < 64; y++)
            for (int x = 0; x < 128; x++)
                if (vram[y][x] !== ref_vram[y][x]) d++;
        return d;
    endfunction

    task automatic clear_vram();
        for (int y = 0; y < 64; y++)
            for (int x = 0; x < 128; x++) begin
                vram[y][x]     = 2'b00;
                ref_vram[y][x] = 2'b00;
            end
    endtask

    task automatic scramble_inputs();
        sprite_x    = HPOS_W'($urandom);
        sprite_y    = VPOS_W'($urandom);
        sprite_rows = 4'($urandom);
        sprite_addr = ADDR_W'($urandom);
        plane_mask  = 2'($urandom);
    endtask

    // Issues one draw and measures its protocol timing; cycle 0 is the cycle
    // in which start is seen. With poke set, extra starts (with junk inputs)
    // are thrown in while busy and in the DONE cycle.
    task automatic do_draw(input int x, input int y, input int n, input int addr,
                           input logic [1:0] mask, input bit poke,
                           output int done_k, output int busy_bad, output logic coll_c1);
        @(negedge clk);
        sprite_x    = HPOS_W'(x);
        sprite_y    = VPOS_W'(y);
        sprite_rows = 4'(n);
        sprite_addr = ADDR_W'(addr);
        plane_mask  = mask;
        start       = 1'b1;
        done_k      = -1;
        busy_bad    = 0;
        coll_c1     = 1'bx;
        for (int k = 1; k <= 700; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (poke) scramble_inputs();
            if (k == 1) coll_c1 = collision;
            if (done === 1'b1) begin
                done_k = k;
                if (busy !== 1'b0) busy_bad++;
                break;
            end
            if (busy !== 1'b1) busy_bad++;
            if (poke && $urandom_range(0, 3) == 0) start = 1'b1;
        end
        if (poke) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (busy !== 1'b0 || done !== 1'b0) busy_bad++;
        @(negedge clk);
        if (busy !== 1'b0 || done !== 1'b0) busy_bad++;
    endtask

    task automatic test_reset();
        logic [31:0] o;
        repeat (3) @(negedge clk);
        o = outs();
        n_cmp++;
        if (o !== 32'h0) begin n_bad++; $display("FAIL reset_outputs: got %h want %h", o, 32'h0); end
        reset_n = 1'b1;
        @(negedge clk);
        o = outs();
        n_cmp++;
        if (o !== 32'h0) begin n_bad++; $display("FAIL idle_outputs: got %h want %h", o, 32'h0); end
    endtask

    task automatic test_basic();
        int dk, bb, wb, rb;
        logic c1;
        clear_vram();
        pmem[0] = 8'hF0;
        wb = act_wq.size();
        rb = act_rq.size();
        model_draw(0, 0, 1, 0, 2'b01);
        do_draw(0, 0, 1, 0, 2'b01, 1'b0, dk, bb, c1);
        n_cmp++; if (dk !== 19) begin n_bad++; $display("FAIL basic_done_cycle: got %0d want %0d", dk, 19); end
        n_cmp++; if (bb !== 0) begin n_bad++; $display("FAIL basic_busy: got %0d bad cycles want 0", bb); end
        n_cmp++; if (act_wq.size() - wb !== 4) begin n_bad++; $display("FAIL basic_write_count: got %0d want 4", act_wq.size() - wb); end
        n_cmp++; if (wq_first_diff(wb, 1'b0) !== -1) begin n_bad++; $display("FAIL basic_writes: first diff at %0d want none", wq_first_diff(wb, 1'b0)); end
        n_cmp++; if (rq_first_diff(rb) !== -1) begin n_bad++; $display("FAIL basic_reads: first diff at %0d want none", rq_first_diff(rb)); end
        n_cmp++; if (collision !== 1'b0) begin n_bad++; $display("FAIL basic_collision: got %b want 0", collision); end
        n_cmp++; if (vram[0][3] !== 2'b01 || vram[0][4] !== 2'b00) begin n_bad++; $display("FAIL basic_pixels: got %b %b want 01 00", vram[0][3], vram[0][4]); end
    endtask

    task automatic test_repeat();
        int dk, bb, wb;
        logic c1;
        wb = act_wq.size();
        model_draw(0, 0, 1, 0, 2'b01);
        do_draw(0, 0, 1, 0, 2'b01, 1'b0, dk, bb, c1);
        n_cmp++; if (dk !== 19) begin n_bad++; $display("FAIL repeat_done_cycle: got %0d want %0d", dk, 19); end
        n_cmp++; if (wq_first_diff(wb, 1'b0) !== -1) begin n_bad++; $display("FAIL repeat_writes: first diff at %0d want none", wq_first_diff(wb, 1'b0)); end
        n_cmp++; if (vram[0][0] !== 2'b00 || vram[0][3] !== 2'b00) begin n_bad++; $display("FAIL repeat_pixels: got %b %b want 00 00", vram[0][0], vram[0][3]); end
        n_cmp++; if (collision !== 1'b1) begin n_bad++; $display("FAIL repeat_collision: got %b want 1", collision); end
        repeat (10) @(negedge clk);
        n_cmp++; if (collision !== 1'b1) begin n_bad++; $display("FAIL collision_held: got %b want 1", collision); end
        // Non-colliding draw elsewhere: collision must drop as soon as it starts.
        pmem[1] = 8'h81;
        model_draw(40, 20, 1, 1, 2'b10);
        do_draw(40, 20, 1, 1, 2'b10, 1'b0, dk, bb, c1);
        n_cmp++; if (c1 !== 1'b0) begin n_bad++; $display("FAIL collision_cleared_on_start: got %b want 0", c1); end
        n_cmp++; if (collision !== exp_coll) begin n_bad++; $display("FAIL second_collision: got %b want %b", collision, exp_coll); end
    endtask

    task automatic test_edge();
        int dk, bb, wb;
        logic c1;
        logic [1:0] mask = 2'($urandom_range(1, 3));
        for (int y = 0; y < 64; y++)
            for (int x = 0; x < 128; x++) begin
                vram[y][x]     = 2'($urandom);
                ref_vram[y][x] = vram[y][x];
            end
        pmem[12'h100] = 8'hFF;
        pmem[12'h101] = 8'hFF;
        wb = act_wq.size();
        model_draw(124, 63, 2, 12'h100, mask);
        do_draw(124, 63, 2, 12'h100, mask, 1'b0, dk, bb, c1);
        n_cmp++; if (dk !== 37) begin n_bad++; $display("FAIL edge_done_cycle: got %0d want %0d", dk, 37); end
`ifdef VDRIVE_SPRITE_WRAP_EN
        n_cmp++; if (act_wq.size() - wb !== 16) begin n_bad++; $display("FAIL edge_write_count: got %0d want 16", act_wq.size() - wb); end
`else
        n_cmp++; if (act_wq.size() - wb !== 4) begin n_bad++; $display("FAIL edge_write_count: got %0d want 4", act_wq.size() - wb); end
`endif
        n_cmp++; if (wq_first_diff(wb, 1'b0) !== -1) begin n_bad++; $display("FAIL edge_writes: first diff at %0d want none", wq_first_diff(wb, 1'b0)); end
        n_cmp++; if (collision !== exp_coll) begin n_bad++; $display("FAIL edge_collision: got %b want %b", collision, exp_coll); end
        n_cmp++; if (vram_diffs() !== 0) begin n_bad++; $display("FAIL edge_vram: got %0d differing pixels want 0", vram_diffs()); end
    endtask

    task automatic test_wide();
        int dk, bb, wb, rb;
        logic c1;
        int x = $urandom_range(0, 127);
        int y = $urandom_range(0, 63);
        logic [1:0] mask = 2'($urandom_range(1, 3));
        for (int i = 0; i < 32; i++) pmem[12'h200 + i] = 8'($urandom);
        wb = act_wq.size();
        rb = act_rq.size();
        model_draw(x, y, 0, 12'h200, mask);
        do_draw(x, y, 0, 12'h200, mask, 1'b0, dk, bb, c1);
        n_cmp++; if (dk !== 577) begin n_bad++; $display("FAIL wide_done_cycle: got %0d want %0d", dk, 577); end
        n_cmp++; if (bb !== 0) begin n_bad++; $display("FAIL wide_busy: got %0d bad cycles want 0", bb); end
        n_cmp++; if (act_rq.size() - rb !== 32) begin n_bad++; $display("FAIL wide_read_count: got %0d want 32", act_rq.size() - rb); end
        n_cmp++; if (rq_first_diff(rb) !== -1) begin n_bad++; $display("FAIL wide_reads: first diff at %0d want none", rq_first_diff(rb)); end
        n_cmp++; if (wq_first_diff(wb, 1'b0) !== -1) begin n_bad++; $display("FAIL wide_writes: first diff at %0d want none", wq_first_diff(wb, 1'b0)); end
        n_cmp++; if (collision !== exp_coll) begin n_bad++; $display("FAIL wide_collision: got %b want %b", collision, exp_coll); end
        n_cmp++; if (vram_diffs() !== 0) begin n_bad++; $display("FAIL wide_vram: got %0d differing pixels want 0", vram_diffs()); end
    endtask

    task automatic test_mask0_pokes();
        int dk, bb, wb;
        logic c1;
        int n = $urandom_range(1, 15);
        int addr = $urandom_range(0, 4095);
        for (int i = 0; i < n; i++) pmem[(addr + i) % 4096] = 8'hFF;
        wb = act_wq.size();
        model_draw(10, 10, n, addr, 2'b00);
        do_draw(10, 10, n, addr, 2'b00, 1'b1, dk, bb, c1);
        n_cmp++; if (dk !== 18 * n + 1) begin n_bad++; $display("FAIL mask0_done_cycle: got %0d want %0d", dk, 18 * n + 1); end
        n_cmp++; if (bb !== 0) begin n_bad++; $display("FAIL mask0_busy_restart: got %0d bad cycles want 0", bb); end
        n_cmp++; if (act_wq.size() - wb !== 0) begin n_bad++; $display("FAIL mask0_writes: got %0d want 0", act_wq.size() - wb); end
        n_cmp++; if (collision !== 1'b0) begin n_bad++; $display("FAIL mask0_collision: got %b want 0", collision); end
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++) begin
            int dk, bb, wb, rb, want;
            logic c1;
            int x = $urandom_range(0, 127);
            int y = $urandom_range(0, 63);
            int n = (t == 2) ? 0 : $urandom_range(0, 15);
            int addr = $urandom_range(0, 4095);
            logic [1:0] mask = 2'($urandom);
            bit poke = 1'($urandom);
            for (int i = 0; i < 32; i++) pmem[(addr + i) % 4096] = 8'($urandom);
            want = (n == 0) ? 577 : 18 * n + 1;
            wb = act_wq.size();
            rb = act_rq.size();
            model_draw(x, y, n, addr, mask);
            do_draw(x, y, n, addr, mask, poke, dk, bb, c1);
            n_cmp++; if (dk !== want) begin n_bad++; $display("FAIL rand%0d_done_cycle: got %0d want %0d", t, dk, want); end
            n_cmp++; if (bb !== 0) begin n_bad++; $display("FAIL rand%0d_busy: got %0d bad cycles want 0", t, bb); end
            n_cmp++; if (rq_first_diff(rb) !== -1) begin n_bad++; $display("FAIL rand%0d_reads: first diff at %0d want none", t, rq_first_diff(rb)); end
            n_cmp++; if (wq_first_diff(wb, 1'b0) !== -1) begin n_bad++; $display("FAIL rand%0d_writes: first diff at %0d want none", t, wq_first_diff(wb, 1'b0)); end
            n_cmp++; if (collision !== exp_coll) begin n_bad++; $display("FAIL rand%0d_collision: got %b want %b", t, collision, exp_coll); end
            n_cmp++; if (vram_diffs() !== 0) begin n_bad++; $display("FAIL rand%0d_vram: got %0d differing pixels want 0", t, vram_diffs()); end
        end
    endtask

    task automatic test_reset_mid();
        int dk, bb, wb, na;
        logic c1;
        logic [31:0] o;
        int x = $urandom_range(0, 127);
        int y = $urandom_range(0, 63);
        int addr = $urandom_range(0, 4095);
        logic [1:0] mask = 2'($urandom_range(1, 3));
        for (int i = 0; i < 5; i++) pmem[(addr + i) % 4096] = 8'($urandom) | 8'h01;
        pre_vram = ref_vram;
        model_draw(x, y, 5, addr, mask);
        wb = act_wq.size();
        @(negedge clk);
        sprite_x    = HPOS_W'(x);
        sprite_y    = VPOS_W'(y);
        sprite_rows = 4'd5;
        sprite_addr = ADDR_W'(addr);
        plane_mask  = mask;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (42) @(negedge clk);   // cycle 43: inside row 2
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL midreset_busy_before: got %b want 1", busy); end
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1 o = outs();
        n_cmp++; if (o !== 32'h0) begin n_bad++; $display("FAIL midreset_outputs_async: got %h want %h", o, 32'h0); end
        @(posedge clk);
        #1 o = outs();
        n_cmp++; if (o !== 32'h0) begin n_bad++; $display("FAIL midreset_outputs_edge: got %h want %h", o, 32'h0); end
        n_cmp++; if (wq_first_diff(wb, 1'b1) !== -1) begin n_bad++; $display("FAIL midreset_partial_writes: first diff at %0d want none", wq_first_diff(wb, 1'b1)); end
        na = act_wq.size() - wb;
        ref_vram = pre_vram;
        for (int i = 0; i < na && i < exp_wq.size(); i++) ref_vram[exp_wq[i].y][exp_wq[i].x] = exp_wq[i].v;
        n_cmp++; if (vram_diffs() !== 0) begin n_bad++; $display("FAIL midreset_vram: got %0d differing pixels want 0", vram_diffs()); end
        @(negedge clk);
        reset_n = 1'b1;
        wb = act_wq.size();
        model_draw(x, y, 5, addr, mask);
        do_draw(x, y, 5, addr, mask, 1'b0, dk, bb, c1);
        n_cmp++; if (dk !== 91) begin n_bad++; $display("FAIL after_reset_done_cycle: got %0d want %0d", dk, 91); end
        n_cmp++; if (wq_first_diff(wb, 1'b0) !== -1) begin n_bad++; $display("FAIL after_reset_writes: first diff at %0d want none", wq_first_diff(wb, 1'b0)); end
        n_cmp++; if (collision !== exp_coll) begin n_bad++; $display("FAIL after_reset_collision: got %b want %b", collision, exp_coll); end
        n_cmp++; if (vram_diffs() !== 0) begin n_bad++; $display("FAIL after_reset_vram: got %0d differing pixels want 0", vram_diffs()); end
    endtask

    initial begin
        reset_n     = 1'b0;
        start       = 1'b0;
        sprite_x    = '0;
        sprite_y    = '0;
        sprite_rows = '0;
        sprite_addr = '0;
        plane_mask  = '0;
        for (int i = 0; i < 4096; i++) pmem[i] = 8'h00;
        clear_vram();
        test_reset();
        test_basic();
        test_repeat();
        test_edge();
        test_wide();
        test_mask0_pokes();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
